// File: rtl/lcd_bus_responder.sv
// lcd_bus_responder: HD44780-style LCD controller model answering a driver's en/RS/RW/LCD bus
// Ports:
//   clk, rstBt (async active-low)     clock and reset
//   en, RS, RW, LCD[7:0]              driver bus, asynchronous to clk
//   LCD_rd[7:0], LCD_oe               read-back data and its drive enable
//   busy, ac[6:0]                     busy flag and address counter
//   disp_ctl[2:0], func_set[2:0]      latched {D,C,B} and {DL,N,F}
//   overrun                           sticky: write seen while busy
//   dbg_addr[6:0] / dbg_data[7:0]     combinational DDRAM peek
module lcd_bus_responder #(
  parameter int BUSY_CYCLES  = 2000,
  parameter int CLEAR_CYCLES = 82000
) (
  input  logic       clk,
  input  logic       rstBt,
  input  logic       en,
  input  logic       RS,
  input  logic       RW,
  input  logic [7:0] LCD,
  output logic [7:0] LCD_rd,
  output logic       LCD_oe,
  output logic       busy,
  output logic [6:0] ac,
  output logic [2:0] disp_ctl,
  output logic [2:0] func_set,
  output logic       overrun,
  input  logic [6:0] dbg_addr,
  output logic [7:0] dbg_data
);
  localparam int CW = $clog2((BUSY_CYCLES > CLEAR_CYCLES ? BUSY_CYCLES : CLEAR_CYCLES) + 1);
  logic [1:0]      en_q, rs_q, rw_q;
  logic [1:0][7:0] lcd_q;
  logic            en_d, en_s, rs_s, rw_s;
  logic [7:0]      d_s;
  logic            id, boot, fill, fall, wr_ok, long_cmd, is_cls;
  logic [6:0]      fptr, ac_step;
  logic [CW-1:0]   cnt;
  logic [7:0]      mem [80];
  assign en_s     = en_q[1];
  assign rs_s     = rs_q[1];
  assign rw_s     = rw_q[1];
  assign d_s      = lcd_q[1];
  assign fall     = en_d & ~en_s;
  assign busy     = (cnt != '0) | fill;
  assign wr_ok    = fall & ~rw_s & ~busy;
  assign long_cmd = ~rs_s & (d_s[7:2] == 6'd0) & (d_s[1:0] != 2'd0);
  assign is_cls   = ~rs_s & (d_s == 8'h01);
  assign ac_step  = id ? (ac == 7'd79 ? 7'd0 : ac + 7'd1) : (ac == 7'd0 ? 7'd79 : ac - 7'd1);
  always_comb begin
    LCD_oe   = en_s & rw_s;
    LCD_rd   = !LCD_oe ? 8'h00 : rs_s ? mem[ac] : {busy, ac};
    dbg_data = dbg_addr <= 7'd79 ? mem[dbg_addr] : 8'h00;
  end
  // boot holds through reset so the 0x20 fill starts on the first clock after release
  always_ff @(posedge clk or negedge rstBt) begin
    if (!rstBt) begin
      en_q     <= '0;
      rs_q     <= '0;
      rw_q     <= '0;
      lcd_q    <= '0;
      en_d     <= 1'b0;
      ac       <= 7'd0;
      id       <= 1'b1;
      disp_ctl <= 3'b000;
      func_set <= 3'b000;
      overrun  <= 1'b0;
      boot     <= 1'b1;
      fill     <= 1'b0;
      fptr     <= 7'd0;
      cnt      <= '0;
    end else begin
      en_q  <= {en_q[0], en};
      rs_q  <= {rs_q[0], RS};
      rw_q  <= {rw_q[0], RW};
      lcd_q <= {lcd_q[0], LCD};
      en_d  <= en_s;
      boot  <= 1'b0;
      cnt   <= cnt != '0 ? cnt - CW'(1) : '0;
      if (fill) begin
        fptr <= fptr + 7'd1;
        if (fptr == 7'd79) fill <= 1'b0;
      end
      if (boot) begin
        fill <= 1'b1;
        fptr <= 7'd0;
      end
      if (fall & ~rw_s & busy) overrun <= 1'b1;
      if (fall & rw_s & rs_s) ac <= ac_step;
      if (wr_ok) begin
        cnt <= long_cmd ? CW'(CLEAR_CYCLES) : CW'(BUSY_CYCLES);
        if (rs_s) ac <= ac_step;
        else
          casez (d_s)
            8'b1???????: if (d_s[6:0] <= 7'h4F) ac <= d_s[6:0];
            8'b001?????: func_set <= d_s[4:2];
            8'b00001???: disp_ctl <= d_s[2:0];
            8'b000001??: id <= d_s[1];
            8'b0000001?: ac <= 7'd0;
            8'b00000001: begin
              ac   <= 7'd0;
              id   <= 1'b1;
              fill <= 1'b1;
              fptr <= 7'd0;
            end
            default: ;
          endcase
      end
    end
  end
  // fill and accepted data writes never coincide: fill implies busy, which blocks writes
  always_ff @(posedge clk) begin
    if (fill) mem[fptr] <= 8'h20;
    else if (wr_ok & rs_s) mem[ac] <= d_s;
  end
endmodule

// File: tb/tb_lcd_bus_responder.sv
// tb_lcd_bus_responder: directed + randomized bus transactions checked against a behavioural LCD model
module tb_lcd_bus_responder;
  localparam int BC = 2000, CC = 3000;
  logic clk = 0, rstBt = 1, en = 0, RS = 0, RW = 0;
  logic [7:0] LCD = 8'h00, LCD_rd, dbg_data;
  logic [6:0] dbg_addr = 7'd0, ac;
  logic LCD_oe, busy, overrun;
  logic [2:0] disp_ctl, func_set;
  int total = 0, passed = 0;
  logic [7:0] m_mem [80];
  int m_ac, m_id, m_disp, m_func, m_ovr;

  lcd_bus_responder #(.BUSY_CYCLES(BC), .CLEAR_CYCLES(CC)) dut (
    .clk(clk), .rstBt(rstBt), .en(en), .RS(RS), .RW(RW), .LCD(LCD),
    .LCD_rd(LCD_rd), .LCD_oe(LCD_oe), .busy(busy), .ac(ac),
    .disp_ctl(disp_ctl), .func_set(func_set), .overrun(overrun),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic m_reset();
    foreach (m_mem[i]) m_mem[i] = 8'h20;
    m_ac = 0; m_id = 1; m_disp = 0; m_func = 0; m_ovr = 0;
  endtask

  task automatic m_step();
    m_ac = m_id != 0 ? (m_ac + 1) % 80 : (m_ac + 79) % 80;
  endtask

  task automatic m_write(input bit rs, input int d, output int cyc);
    cyc = BC;
    if (rs) begin m_mem[m_ac] = 8'(d); m_step(); end
    else if (d >= 128) begin if (d - 128 <= 79) m_ac = d - 128; end
    else if (d >= 64) cyc = BC;
    else if (d >= 32) m_func = (d >> 2) & 7;
    else if (d >= 16) cyc = BC;
    else if (d >= 8) m_disp = d & 7;
    else if (d >= 4) m_id = (d >> 1) & 1;
    else if (d >= 2) begin m_ac = 0; cyc = CC; end
    else if (d == 1) begin foreach (m_mem[i]) m_mem[i] = 8'h20; m_ac = 0; m_id = 1; cyc = CC; end
  endtask

  task automatic bus(input bit rs, input bit rw, input logic [7:0] d);
    @(negedge clk);
    RS = rs; RW = rw; LCD = d;
    repeat (2) @(negedge clk);
    en = 1;
    repeat (4) @(negedge clk);
  endtask

  task automatic check_ddram(input string tag);
    int bad = 0;
    for (int i = 0; i < 80; i++) begin
      dbg_addr = 7'(i);
      #1;
      if (dbg_data !== m_mem[i]) bad++;
    end
    check(tag, bad, 0);
  endtask

  task automatic wr_start(input bit rs, input logic [7:0] d, input string tag, output int cyc);
    int n = 0;
    m_write(rs, int'(d), cyc);
    bus(rs, 1'b0, d);
    en = 0;
    while (!busy && n < 10) begin @(negedge clk); n++; end
    check({tag, "_busy_rise"}, busy, 1);
    check({tag, "_ac_now"}, ac, m_ac);
  endtask

  task automatic wr_finish(input int cyc, input int already, input string tag);
    int n = already;
    while (busy && n < cyc + 10) begin @(negedge clk); n++; end
    check({tag, "_busy_len"}, n, cyc);
    check({tag, "_ac"}, ac, m_ac);
    check({tag, "_func"}, func_set, m_func);
    check({tag, "_disp"}, disp_ctl, m_disp);
    check({tag, "_ovr"}, overrun, m_ovr);
    repeat (3) @(negedge clk);
  endtask

  task automatic do_write(input bit rs, input logic [7:0] d, input string tag);
    int cyc;
    wr_start(rs, d, tag, cyc);
    wr_finish(cyc, 0, tag);
  endtask

  task automatic do_read(input bit rs, input bit bsy, input string tag);
    logic [7:0] exp;
    bus(rs, 1'b1, 8'h00);
    exp = rs ? m_mem[m_ac] : {bsy, 7'(m_ac)};
    check({tag, "_oe"}, LCD_oe, 1);
    check({tag, "_rd"}, LCD_rd, exp);
    en = 0;
    repeat (4) @(negedge clk);
    if (rs) m_step();
    check({tag, "_oe_off"}, LCD_oe, 0);
    check({tag, "_rd_off"}, LCD_rd, 0);
    check({tag, "_ac"}, ac, m_ac);
  endtask

  initial begin
    int cyc, n;
    #1 rstBt = 0;
    #3;
    m_reset();
    check("rst_busy", busy, 0);
    check("rst_ac", ac, 0);
    check("rst_oe", LCD_oe, 0);
    check("rst_rd", LCD_rd, 0);
    check("rst_ovr", overrun, 0);
    check("rst_disp", disp_ctl, 0);
    check("rst_func", func_set, 0);
    repeat (3) @(negedge clk);
    rstBt = 1;
    n = 0;
    while (!busy && n < 10) begin @(negedge clk); n++; end
    n = 0;
    while (busy && n < 200) begin @(negedge clk); n++; end
    check("fill_len", n, 80);
    check_ddram("init_ddram");

    do_write(0, 8'h38, "fs");
    check("fs_const", func_set, 3'b110);

    do_write(0, 8'hCF, "ac4f");
    do_write(1, 8'h41, "d41");
    do_write(1, 8'h42, "d42");
    dbg_addr = 7'h4F; #1 check("wrap_4f", dbg_data, 8'h41);
    dbg_addr = 7'h00; #1 check("wrap_00", dbg_data, 8'h42);
    check("wrap_ac", ac, 1);

    do_write(0, 8'h04, "dec");
    do_write(0, 8'h80, "ac00");
    do_write(1, 8'h5A, "d5a");
    dbg_addr = 7'h00; #1 check("dec_00", dbg_data, 8'h5A);
    check("dec_ac", ac, 7'h4F);
    check_ddram("dec_ddram");

    for (int k = 0; k < 10; k++) begin
      int op;
      logic [7:0] d;
      op = $urandom_range(0, 5);
      d = op == 0 ? (8'h80 | 8'($urandom_range(0, 127))) :
          op == 3 ? (8'h04 | 8'($urandom_range(0, 3))) :
          op == 4 ? (8'h08 | 8'($urandom_range(0, 7))) :
          op == 5 ? (8'h20 | 8'($urandom_range(0, 31))) : 8'($urandom);
      do_write(op == 1 || op == 2, d, "rand_wr");
      do_read(1, 0, "rand_rd");
      do_read(0, 0, "rand_st");
    end
    check_ddram("rand_ddram");

    wr_start(0, 8'h01, "clr", cyc);
    do_read(0, 1, "clr_status");
    check("clr_status_const", LCD_rd == 8'h00 && ac == 7'd0, 1);
    wr_finish(cyc, 11, "clr");
    check_ddram("clr_ddram");

    do_write(1, 8'h33, "pre_ovr");
    wr_start(0, 8'h0C, "ovr_cmd", cyc);
    repeat (10) @(negedge clk);
    bus(1, 1'b0, 8'h77);
    en = 0;
    repeat (4) @(negedge clk);
    m_ovr = 1;
    check("ovr_set", overrun, 1);
    wr_finish(cyc, 21, "ovr");
    check_ddram("ovr_ddram");
    do_read(0, 0, "ovr_st");
    check("ovr_sticky", overrun, 1);

    wr_start(0, 8'h01, "clr2", cyc);
    repeat (200) @(negedge clk);
    #2 rstBt = 0;
    #1;
    m_reset();
    check("abort_busy", busy, 0);
    check("abort_ac", ac, 0);
    check("abort_ovr", overrun, 0);
    check("abort_disp", disp_ctl, 0);
    @(negedge clk);
    rstBt = 1;
    repeat (2) @(negedge clk);
    n = 0;
    while (busy && n < 200) begin @(negedge clk); n++; end
    check("abort_fill_done", busy, 0);
    check_ddram("abort_ddram");
    do_write(1, 8'h61, "post_rst");
    check_ddram("post_rst_ddram");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
